// File: rtl/iter_alu.sv
// Iterative ALU. Logic, add/sub, compare and shift ops finish in one cycle.
// Multiply and divide use a shift-add or restoring shift-subtract datapath, one bit per cycle.
module iter_alu #(
  parameter int WIDTH = 32,
  parameter int CNT_W = $clog2(WIDTH) + 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [3:0]       op,
  input  logic [WIDTH-1:0] src_a,
  input  logic [WIDTH-1:0] src_b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             zero
);
  localparam int SH_W = $clog2(WIDTH);
  localparam logic [WIDTH-1:0] MIN_NEG = {1'b1, {(WIDTH-1){1'b0}}};

  typedef enum logic [1:0] {IDLE, RUN, FINISH} state_t;
  typedef struct packed {
    logic [3:0] op;
    logic       neg_q;
    logic       neg_r;
  } req_t;

  state_t           state, state_nxt;
  req_t             req;
  logic [CNT_W-1:0] cnt;
  logic [WIDTH-1:0] hi, lo, mcand;
  logic [WIDTH-1:0] step_hi, step_lo, fin_raw, fin_res, sc_res;
  logic [WIDTH-1:0] abs_a, abs_b;
  logic [WIDTH:0]   mul_sum, div_sh, div_diff;
  logic             iter_op, is_div, is_sdiv, short_div, neg_a, neg_b, fin_neg;

  assign iter_op   = op[3] & (op[2] | op[1]);
  assign is_div    = op[3] & op[2];
  assign is_sdiv   = (op[3:1] == 3'b111);
  assign short_div = is_div & ((src_b == '0) |
                               (is_sdiv & (src_a == MIN_NEG) & (src_b == '1)));
  assign neg_a     = is_sdiv & src_a[WIDTH-1];
  assign neg_b     = is_sdiv & src_b[WIDTH-1];
  assign abs_a     = neg_a ? -src_a : src_a;
  assign abs_b     = neg_b ? -src_b : src_b;
  assign busy      = (state != IDLE);

  // Single-cycle results; the default arm holds the divide short-circuit values.
  always_comb begin
    sc_res = '0;
    case (op)
      4'd0: sc_res = src_a & src_b;
      4'd1: sc_res = src_a | src_b;
      4'd2: sc_res = src_a + src_b;
      4'd3: sc_res = src_a - src_b;
      4'd4: sc_res = src_a ^ src_b;
      4'd5: sc_res = {{(WIDTH-1){1'b0}}, $signed(src_a) < $signed(src_b)};
      4'd6: sc_res = {{(WIDTH-1){1'b0}}, src_a < src_b};
      4'd7: sc_res = src_a << src_b[SH_W-1:0];
      4'd8: sc_res = src_a >> src_b[SH_W-1:0];
      4'd9: sc_res = WIDTH'($signed(src_a) >>> src_b[SH_W-1:0]);
      default: begin
        if (src_b == '0) sc_res = op[0] ? src_a : '1;
        else             sc_res = op[0] ? '0 : src_a;
      end
    endcase
  end

  // One multiply or divide step on {hi, lo}; FINISH applies the last step combinationally.
  always_comb begin
    mul_sum  = {1'b0, hi} + (lo[0] ? {1'b0, mcand} : {(WIDTH+1){1'b0}});
    div_sh   = {hi, lo[WIDTH-1]};
    div_diff = div_sh - {1'b0, mcand};
    if (req.op[2]) begin
      step_hi = div_diff[WIDTH] ? div_sh[WIDTH-1:0] : div_diff[WIDTH-1:0];
      step_lo = {lo[WIDTH-2:0], ~div_diff[WIDTH]};
    end else begin
      step_hi = mul_sum[WIDTH:1];
      step_lo = {mul_sum[0], lo[WIDTH-1:1]};
    end
    fin_raw = req.op[0] ? step_hi : step_lo;
    fin_neg = req.op[0] ? req.neg_r : req.neg_q;
    fin_res = fin_neg ? -fin_raw : fin_raw;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start && iter_op && !short_div) state_nxt = RUN;
      // Leave when the counter is about to reach 1: WIDTH-1 RUN steps plus the FINISH step.
      RUN:     if (cnt == CNT_W'(2)) state_nxt = FINISH;
      FINISH:  state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      done   <= 1'b0;
      result <= '0;
      zero   <= 1'b1;
      cnt    <= '0;
      hi     <= '0;
      lo     <= '0;
      mcand  <= '0;
      req    <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: if (start) begin
          if (iter_op && !short_div) begin
            req   <= '{op: op, neg_q: neg_a ^ neg_b, neg_r: neg_a};
            cnt   <= CNT_W'(WIDTH);
            hi    <= '0;
            lo    <= is_div ? abs_a : src_b;
            mcand <= is_div ? abs_b : src_a;
          end else begin
            result <= sc_res;
            zero   <= (sc_res == '0);
            done   <= 1'b1;
          end
        end
        RUN: begin
          hi  <= step_hi;
          lo  <= step_lo;
          cnt <= cnt - 1'b1;
        end
        FINISH: begin
          result <= fin_res;
          zero   <= (fin_res == '0);
          done   <= 1'b1;
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_iter_alu.sv
// Directed self-checking bench for iter_alu: a 32-bit instance and an 8-bit instance.
module tb_iter_alu;
  logic        clk, reset;
  logic        start, busy, done, zero;
  logic [3:0]  op;
  logic [31:0] a, b, result;
  logic        s8_start, s8_busy, s8_done, s8_zero;
  logic [3:0]  s8_op;
  logic [7:0]  s8_a, s8_b, s8_result;

  int checks = 0;
  int errors = 0;

  iter_alu #(.WIDTH(32)) dut32 (
    .clk(clk), .reset(reset), .start(start), .op(op), .src_a(a), .src_b(b),
    .busy(busy), .done(done), .result(result), .zero(zero));

  iter_alu #(.WIDTH(8)) dut8 (
    .clk(clk), .reset(reset), .start(s8_start), .op(s8_op), .src_a(s8_a), .src_b(s8_b),
    .busy(s8_busy), .done(s8_done), .result(s8_result), .zero(s8_zero));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // Issue one op (accepted at edge k), then wait for done. lat = cycles from k to done.
  task automatic go32(input logic [3:0] o, input logic [31:0] x, input logic [31:0] y,
                      output logic [31:0] res, output int lat, output int bcnt);
    @(negedge clk); start = 1'b1; op = o; a = x; b = y;
    @(posedge clk); #1; start = 1'b0;
    lat = 1; bcnt = 0;
    while (!done && lat < 100) begin
      if (busy) bcnt++;
      @(posedge clk); #1; lat++;
    end
    res = result;
  endtask

  task automatic t32(input string tag, input logic [3:0] o, input logic [31:0] x,
                     input logic [31:0] y, input logic [31:0] exp, input int exp_lat);
    logic [31:0] r;
    int lat, bc;
    go32(o, x, y, r, lat, bc);
    chk({tag, "_res"}, r, exp);
    chk({tag, "_lat"}, lat, exp_lat);
  endtask

  task automatic go8(input logic [3:0] o, input logic [7:0] x, input logic [7:0] y,
                     output logic [7:0] res, output int lat);
    @(negedge clk); s8_start = 1'b1; s8_op = o; s8_a = x; s8_b = y;
    @(posedge clk); #1; s8_start = 1'b0;
    lat = 1;
    while (!s8_done && lat < 100) begin
      @(posedge clk); #1; lat++;
    end
    res = s8_result;
  endtask

  initial begin
    logic [31:0] r;
    logic [7:0]  r8;
    int lat, bc, ndone;

    reset = 1'b1; start = 1'b0; op = '0; a = '0; b = '0;
    s8_start = 1'b0; s8_op = '0; s8_a = '0; s8_b = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_result", result, 0);
    chk("rst_zero", zero, 1);
    reset = 1'b0;

    // Reset aborts an in-flight multiply
    t32("add3", 4'd2, 32'd1, 32'd2, 32'd3, 1);
    @(negedge clk); start = 1'b1; op = 4'd10; a = 32'd7; b = 32'd6;
    @(posedge clk); #1; start = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    chk("abort_busy_before", busy, 1);
    @(negedge clk); reset = 1'b1;
    @(posedge clk); #1; reset = 1'b0;
    chk("abort_busy", busy, 0);
    chk("abort_done", done, 0);
    chk("abort_result", result, 0);
    chk("abort_zero", zero, 1);
    ndone = 0;
    repeat (40) begin
      @(posedge clk); #1;
      if (done || busy) ndone++;
    end
    chk("abort_no_done", ndone, 0);
    t32("mul7x6", 4'd10, 32'd7, 32'd6, 32'd42, 33);

    // Single-cycle ops
    t32("add_wrap", 4'd2, 32'hFFFF_FFFF, 32'd1, 32'h0, 1);
    chk("add_wrap_zero", zero, 1);
    t32("sub", 4'd3, 32'd5, 32'd7, 32'hFFFF_FFFE, 1);
    chk("sub_zero", zero, 0);
    t32("slt", 4'd5, 32'hFFFF_FFFF, 32'd1, 32'd1, 1);
    t32("sltu", 4'd6, 32'hFFFF_FFFF, 32'd1, 32'd0, 1);
    t32("sra", 4'd9, 32'h8000_0000, 32'd4, 32'hF800_0000, 1);
    t32("sll", 4'd7, 32'd1, 32'd31, 32'h8000_0000, 1);
    t32("srl_mask", 4'd8, 32'h8000_0000, 32'h24, 32'h0800_0000, 1);
    t32("and", 4'd0, 32'hF0F0_F0F0, 32'hFF00_FF00, 32'hF000_F000, 1);
    t32("or", 4'd1, 32'hF0F0_F0F0, 32'hFF00_FF00, 32'hFFF0_FFF0, 1);
    t32("xor", 4'd4, 32'hF0F0_F0F0, 32'hFF00_FF00, 32'h0FF0_0FF0, 1);

    // Multiply
    go32(4'd10, 32'h0001_0000, 32'h0001_0000, r, lat, bc);
    chk("mul16_res", r, 0);
    chk("mul16_zero", zero, 1);
    chk("mul16_lat", lat, 33);
    chk("mul16_busy_cycles", bc, 32);
    chk("mul16_busy_at_done", busy, 0);
    t32("mulhu16", 4'd11, 32'h0001_0000, 32'h0001_0000, 32'd1, 33);
    t32("mul_ff", 4'd10, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd1, 33);
    t32("mulhu_ff", 4'd11, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 33);

    // Divide
    t32("div_m7_2", 4'd14, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 33);
    t32("rem_m7_2", 4'd15, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 33);
    t32("div_7_m2", 4'd14, 32'd7, 32'hFFFF_FFFE, 32'hFFFF_FFFD, 33);
    t32("rem_7_m2", 4'd15, 32'd7, 32'hFFFF_FFFE, 32'd1, 33);
    t32("divu", 4'd12, 32'd100, 32'd7, 32'd14, 33);
    t32("remu", 4'd13, 32'd100, 32'd7, 32'd2, 33);

    // Divide short-circuits
    t32("div_by0", 4'd14, 32'd9, 32'd0, 32'hFFFF_FFFF, 1);
    t32("rem_by0", 4'd15, 32'd9, 32'd0, 32'd9, 1);
    t32("divu_by0", 4'd12, 32'd9, 32'd0, 32'hFFFF_FFFF, 1);
    t32("div_ovf", 4'd14, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1);
    t32("rem_ovf", 4'd15, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 1);
    chk("rem_ovf_zero", zero, 1);

    // Start pulsed while busy is ignored; operand changes have no effect
    @(negedge clk); start = 1'b1; op = 4'd12; a = 32'd100; b = 32'd7;
    @(posedge clk); #1; start = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    @(negedge clk); start = 1'b1; op = 4'd2; a = 32'd1; b = 32'd1;
    @(posedge clk); #1; start = 1'b0; op = 4'd0; a = '0; b = '0;
    chk("ign_done", done, 0);
    chk("ign_busy", busy, 1);
    lat = 4;
    while (!done && lat < 100) begin
      @(posedge clk); #1; lat++;
    end
    chk("ign_res", result, 14);
    chk("ign_lat", lat, 33);
    @(posedge clk); #1;
    chk("ign_no_queue", done | busy, 0);

    // 8-bit instance, second op issued in the done cycle of the first
    go8(4'd11, 8'hFF, 8'hFF, r8, lat);
    chk("w8_mulhu_res", r8, 8'hFE);
    chk("w8_mulhu_lat", lat, 9);
    go8(4'd12, 8'd200, 8'd7, r8, lat);
    chk("w8_b2b_res", r8, 8'd28);
    chk("w8_b2b_lat", lat, 9);
    go8(4'd9, 8'h80, 8'd3, r8, lat);
    chk("w8_sra_res", r8, 8'hF0);
    chk("w8_sra_lat", lat, 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
